watch_ctrl: RTL and testbench

WATCH_CTRL -- requirements
Module: watch_ctrl

---
 rtl/watch_ctrl.sv | 141 ++++++++++++++
 tb/tb_watch_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/watch_ctrl.sv
// Stopwatch controller: debounces start/stop and lap/clear buttons, runs the
// CLEAR/ZERO/RUN/LAP/STOPPED state machine and drives counter enable/clear/hold.
// Latency: press pulse 2+DEB_CNT cycles after raw input settles; outputs follow next edge.
// Optional lap feature: define WATCH_LAP_EN to enable the LAP (display hold) state.
module watch_ctrl #(
  parameter int unsigned DEB_CNT = 16
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       LOCKED,
  input  logic       STRTSTOP,
  input  logic       LAPRST,
  output logic       CLKEN,
  output logic       RST,
  output logic       HOLD,
  output logic [2:0] STATE
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CNT - 1);

  typedef enum logic [2:0] {
    S_CLEAR   = 3'd0,
    S_ZERO    = 3'd1,
    S_RUN     = 3'd2,
    S_LAP     = 3'd3,
    S_STOPPED = 3'd4
  } state_e;

  // Bit 0 is the start/stop button, bit 1 the lap/clear button.
  logic [1:0]            sync1_q, sync2_q;
  logic [1:0]            lvl_q, lvl_d;
  logic [1:0]            pulse_q, pulse_d;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;

  state_e state_q, state_d;
  logic   clken_q, rst_q, hold_q;
  logic   clken_d, rst_d, hold_d;
  logic   ss_p, lap_p, lap_run;

  // Synchronizers, debounce state and press pulses.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q <= '0;
      sync2_q <= '0;
      lvl_q   <= '0;
      pulse_q <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= {LAPRST, STRTSTOP};
      sync2_q <= sync1_q;
      lvl_q   <= lvl_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  // Debounce: count consecutive samples that disagree with the level; flip on the last one.
  always_comb begin
    lvl_d   = lvl_q;
    cnt_d   = cnt_q;
    pulse_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == lvl_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        lvl_d[i]   = ~lvl_q[i];
        cnt_d[i]   = '0;
        pulse_d[i] = ~lvl_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  assign ss_p  = pulse_q[0];
  assign lap_p = pulse_q[1];

  // A lap press only acts in RUN when the lap feature exists; start/stop always wins.
`ifdef WATCH_LAP_EN
  assign lap_run = lap_p & ~ss_p;
`else
  assign lap_run = 1'b0;
`endif

  // State register and registered decoded outputs, updated together.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_CLEAR;
      clken_q <= 1'b0;
      rst_q   <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      clken_q <= clken_d;
      rst_q   <= rst_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state logic and output decode from the next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      // Straight out of reset RST is still low, so CLEAR is held one extra
      // edge to give the counter its one-cycle clear pulse.
      S_CLEAR:   state_d = rst_q ? S_ZERO : S_CLEAR;
      S_ZERO:    if (ss_p && LOCKED) state_d = S_RUN;
      S_RUN: begin
        if (ss_p || !LOCKED) state_d = S_STOPPED;
        else if (lap_run)    state_d = S_LAP;
      end
      S_LAP: begin
        if (ss_p || !LOCKED) state_d = S_STOPPED;
        else if (lap_p)      state_d = S_RUN;
      end
      S_STOPPED: begin
        if (ss_p) begin
          if (LOCKED) state_d = S_RUN;
        end else if (lap_p) begin
          state_d = S_CLEAR;
        end
      end
      default:   state_d = S_CLEAR;
    endcase

    clken_d = (state_d == S_RUN) || (state_d == S_LAP);
    rst_d   = (state_d == S_CLEAR);
`ifdef WATCH_LAP_EN
    hold_d  = (state_d == S_LAP);
`else
    hold_d  = 1'b0;
`endif
  end

  assign CLKEN = clken_q;
  assign RST   = rst_q;
  assign HOLD  = hold_q;
  assign STATE = state_q;

endmodule

// File: tb/tb_watch_ctrl.sv
// Bench for watch_ctrl with DEB_CNT=4: reset sequencing, press latency,
// state transitions from a vector table, clear pulse and asynchronous reset.
module tb_watch_ctrl;

  logic       CLK = 1'b0;
  logic       RESET_N, LOCKED, STRTSTOP, LAPRST;
  logic       CLKEN, RST, HOLD;
  logic [2:0] STATE;

  int n_chk = 0;
  int n_err = 0;

  watch_ctrl #(.DEB_CNT(4)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .LOCKED(LOCKED), .STRTSTOP(STRTSTOP),
    .LAPRST(LAPRST), .CLKEN(CLKEN), .RST(RST), .HOLD(HOLD), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  localparam logic [2:0] A_SS = 3'd0, A_LAP = 3'd1, A_BOTH = 3'd2,
                         A_LOCK0 = 3'd3, A_LOCK1 = 3'd4, A_IDLE = 3'd5;

  typedef struct packed {
    logic [2:0] st;
    logic       ck;
    logic       rs;
    logic       hd;
  } exp_t;

  typedef struct packed {
    logic [2:0] act;
    exp_t       e;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];
  exp_t sb[$];

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_all(input string nm, input exp_t e);
    check({nm, ".state"}, 32'(STATE), 32'(e.st));
    check({nm, ".clken"}, 32'(CLKEN), 32'(e.ck));
    check({nm, ".rst"},   32'(RST),   32'(e.rs));
    check({nm, ".hold"},  32'(HOLD),  32'(e.hd));
  endtask

  // Hold the chosen buttons long enough to debounce, then release fully.
  task automatic press(input logic ss, input logic lap);
    STRTSTOP = ss;
    LAPRST   = lap;
    repeat (8) tick();
    STRTSTOP = 1'b0;
    LAPRST   = 1'b0;
    repeat (8) tick();
  endtask

  function automatic vec_t mk(input logic [2:0] act, input logic [2:0] st,
                              input logic ck, input logic hd);
    vec_t v;
    v.act  = act;
    v.e.st = st;
    v.e.ck = ck;
    v.e.rs = 1'b0;
    v.e.hd = hd;
    return v;
  endfunction

  initial begin
    exp_t e;
    RESET_N  = 1'b0;
    LOCKED   = 1'b1;
    STRTSTOP = 1'b0;
    LAPRST   = 1'b0;

    // Table starts in RUN (left there by the press-latency sequence).
`ifdef WATCH_LAP_EN
    vecs[0]  = mk(A_LAP,   3'd3, 1'b1, 1'b1);
    vecs[1]  = mk(A_LAP,   3'd2, 1'b1, 1'b0);
    vecs[2]  = mk(A_LOCK0, 3'd4, 1'b0, 1'b0);
    vecs[3]  = mk(A_SS,    3'd4, 1'b0, 1'b0);
    vecs[4]  = mk(A_LOCK1, 3'd4, 1'b0, 1'b0);
    vecs[5]  = mk(A_SS,    3'd2, 1'b1, 1'b0);
    vecs[6]  = mk(A_LAP,   3'd3, 1'b1, 1'b1);
    vecs[7]  = mk(A_BOTH,  3'd4, 1'b0, 1'b0);
    vecs[8]  = mk(A_SS,    3'd2, 1'b1, 1'b0);
    vecs[9]  = mk(A_LOCK0, 3'd4, 1'b0, 1'b0);
    vecs[10] = mk(A_LOCK1, 3'd4, 1'b0, 1'b0);
    vecs[11] = mk(A_BOTH,  3'd2, 1'b1, 1'b0);
    vecs[12] = mk(A_SS,    3'd4, 1'b0, 1'b0);
`else
    vecs[0]  = mk(A_LAP,   3'd2, 1'b1, 1'b0);
    vecs[1]  = mk(A_LAP,   3'd2, 1'b1, 1'b0);
    vecs[2]  = mk(A_LOCK0, 3'd4, 1'b0, 1'b0);
    vecs[3]  = mk(A_SS,    3'd4, 1'b0, 1'b0);
    vecs[4]  = mk(A_LOCK1, 3'd4, 1'b0, 1'b0);
    vecs[5]  = mk(A_SS,    3'd2, 1'b1, 1'b0);
    vecs[6]  = mk(A_BOTH,  3'd4, 1'b0, 1'b0);
    vecs[7]  = mk(A_SS,    3'd2, 1'b1, 1'b0);
    vecs[8]  = mk(A_LOCK0, 3'd4, 1'b0, 1'b0);
    vecs[9]  = mk(A_LOCK1, 3'd4, 1'b0, 1'b0);
    vecs[10] = mk(A_BOTH,  3'd2, 1'b1, 1'b0);
    vecs[11] = mk(A_SS,    3'd4, 1'b0, 1'b0);
    vecs[12] = mk(A_IDLE,  3'd4, 1'b0, 1'b0);
`endif

    // Reset held: everything low, state CLEAR.
    repeat (3) tick();
    check_all("in_reset", '{st: 3'd0, ck: 1'b0, rs: 1'b0, hd: 1'b0});

    // Release: one cycle of CLEAR with RST, then ZERO.
    RESET_N = 1'b1;
    tick();
    check_all("rel1", '{st: 3'd0, ck: 1'b0, rs: 1'b1, hd: 1'b0});
    tick();
    check_all("rel2", '{st: 3'd1, ck: 1'b0, rs: 1'b0, hd: 1'b0});

    // Bouncy start press: high 2, low 1, high 8; exactly 6 edges after the last rise.
    STRTSTOP = 1'b1;
    repeat (2) tick();
    STRTSTOP = 1'b0;
    tick();
    STRTSTOP = 1'b1;
    repeat (6) tick();
    check("lat_before.state", 32'(STATE), 32'd1);
    check("lat_before.clken", 32'(CLKEN), 32'd0);
    tick();
    check("lat_after.state", 32'(STATE), 32'd2);
    check("lat_after.clken", 32'(CLKEN), 32'd1);
    tick();
    STRTSTOP = 1'b0;
    repeat (8) tick();
    check("no_repeat.state", 32'(STATE), 32'd2);

    // Table-driven transitions, expectations queued when stimulus goes out.
    for (int i = 0; i < NV; i++) begin
      sb.push_back(vecs[i].e);
      case (vecs[i].act)
        A_SS:    press(1'b1, 1'b0);
        A_LAP:   press(1'b0, 1'b1);
        A_BOTH:  press(1'b1, 1'b1);
        A_LOCK0: begin LOCKED = 1'b0; tick(); end
        A_LOCK1: begin LOCKED = 1'b1; tick(); end
        default: repeat (4) tick();
      endcase
      e = sb.pop_front();
      check_all($sformatf("v%0d", i), e);
    end

    // From STOPPED, lap clears: CLEAR with RST for one cycle, then ZERO.
    LAPRST = 1'b1;
    repeat (7) tick();
    check_all("clr1", '{st: 3'd0, ck: 1'b0, rs: 1'b1, hd: 1'b0});
    tick();
    check_all("clr2", '{st: 3'd1, ck: 1'b0, rs: 1'b0, hd: 1'b0});
    LAPRST = 1'b0;
    repeat (8) tick();

    // Lap press in ZERO does nothing; start goes to RUN.
    press(1'b0, 1'b1);
    check("zero_lap.state", 32'(STATE), 32'd1);
    press(1'b1, 1'b0);
    check("run_again.clken", 32'(CLKEN), 32'd1);

    // Asynchronous reset mid-RUN takes effect before the next clock edge.
    @(posedge CLK);
    #2 RESET_N = 1'b0;
    #1;
    check("arst.clken", 32'(CLKEN), 32'd0);
    check("arst.state", 32'(STATE), 32'd0);
    tick();
    RESET_N = 1'b1;
    tick();
    check_all("rerel1", '{st: 3'd0, ck: 1'b0, rs: 1'b1, hd: 1'b0});
    tick();
    check_all("rerel2", '{st: 3'd1, ck: 1'b0, rs: 1'b0, hd: 1'b0});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
